fn_sw_sched: RTL and testbench
==============================

# fn_sw_sched

Bit-serial scheduler sharing one single-bit AND/XOR function unit between two requesters. Each requester submits a W-bit operand pair plus a function select. The scheduler arbitrates, streams the operands LSB-first through the shared unit one bit per cycle, and returns the assembled W-bit result tagged with the requester id. It sits between client logic and the function-switch datapath, trading throughput for a single shared 1-bit unit.

## Interface
- W, default 8, operand and result width (W >= 2)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  request from requester 0 / 1; held until matching gnt seen
- a0, b0 / a1, b1  in  W  operands of requester 0 / 1; stable while req high
- sel0 / sel1  in  1  function select: 1 = a^b, 0 = a&b
- gnt0 / gnt1  out  1  one-cycle pulse, request accepted and operands captured
- y  out  W  result; holds until next completion
- y_vld  out  1  one-cycle pulse, y and y_id valid
- y_id  out  1  requester that owns y
- busy  out  1  high whenever state != IDLE

## Operation
- Reset values: state IDLE; gnt0 = gnt1 = 0; y = 0; y_vld = 0; y_id = 0; busy = 0; last_id = 1; bit counter = 0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE: when any req is high at a rising edge:
  - Select the winner.
  - Capture its a, b, sel into internal shift registers; record the id.
  - Pulse the matching gnt for one cycle; clear the counter; go to RUN.
  - With no req, stay in IDLE.
- Arbitration:
  - Single requester: it wins.
  - Both requesters: the winner is the one != last_id (round-robin, see Configuration).
- RUN: each edge processes captured bit [cnt]:
  - Result bit = sel ? a[cnt]^b[cnt] : a[cnt]&b[cnt].
  - Shift the result bit into the result register from the MSB side; increment cnt.
  - At cnt == W-1, load y with the completed word, set y_id, pulse y_vld, go to DONE.
- DONE: one cycle.
  - Update last_id = y_id; return to IDLE.
  - y_vld deasserts at the next edge.
- No arithmetic: bitwise only. cnt is $clog2(W) bits wide and never wraps; DONE is entered exactly at W-1.
- Operand or req changes after capture have no effect on the in-flight operation.
- Requests arriving during RUN or DONE wait. No gnt is issued outside IDLE.
- Asynchronous reset mid-operation:
  - All outputs go to reset values immediately.
  - The in-flight operation is discarded; no y_vld is produced.
  - last_id returns to 1.

## Timing
- E0: edge at which the req is sampled in IDLE. gnt is high during the cycle after E0.
- Edges E1..EW each process one bit.
- y_vld is high during the cycle following EW. Result latency is W edges after capture.
- At E(W+1), state returns to IDLE. The earliest next capture is E(W+2).
- Back-to-back throughput: one operation per W+2 cycles.
- busy rises in the cycle after E0 and falls in the cycle after E(W+1).
- A requester keeping req high after its gnt is treated as a new request at the next IDLE.

## Configuration
- FN_SW_SCHED_RR_EN defined: round-robin on tie, using last_id as above.
- FN_SW_SCHED_RR_EN undefined: fixed priority, req0 always wins a tie; last_id is unused.
- All other behaviour is identical in both builds.

## Test plan
- Reset then req0, a0=8'hA5, b0=8'h0F, sel0=1:
  - gnt0 pulses after E0.
  - y_vld after E8 with y=8'hAA, y_id=0.
  - busy low again after E9.
- req1, a1=8'hF0, b1=8'h3C, sel1=0 -> y=8'h30, y_id=1, gnt0 never asserts.
- Operands altered to 8'h00 the cycle after gnt0 (a0=8'hFF, b0=8'h81, sel0=1) -> y=8'h7E, unaffected.
- req0 and req1 held high continuously, each pair re-armed after its gnt:
  - With FN_SW_SCHED_RR_EN: y_id sequence 0,1,0,1, one result every 10 cycles.
  - Without the macro: all y_id=0.
- req1 raised during requester 0's RUN -> gnt1 only at E10, y_vld for id 1 after E18.
- rst_n pulled low at the 4th RUN cycle:
  - All outputs 0 immediately; no y_vld.
  - After release, simultaneous req0/req1 -> gnt0 first (last_id=1).

Source files
------------

// File: rtl/fn_sw_sched_if.sv
// Request/operand/result bundle between client logic and the fn_sw_sched
// bit-serial scheduler.
interface fn_sw_sched_if #(
  parameter int W = 8
);
  logic         req0;
  logic         req1;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         sel0;
  logic         sel1;
  logic         gnt0;
  logic         gnt1;
  logic [W-1:0] y;
  logic         y_vld;
  logic         y_id;
  logic         busy;

  modport master (
    output req0, req1, a0, b0, a1, b1, sel0, sel1,
    input  gnt0, gnt1, y, y_vld, y_id, busy
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, sel0, sel1,
    output gnt0, gnt1, y, y_vld, y_id, busy
  );
endinterface

// File: rtl/fn_sw_sched.sv
// Shares one 1-bit AND/XOR unit between two requesters, streaming operands LSB-first.
// Define FN_SW_SCHED_RR_EN for round-robin tie breaking; otherwise req0 wins ties.
module fn_sw_sched #(
  parameter int W = 8
) (
  input logic           clk,
  input logic           rst_n,
  fn_sw_sched_if.slave  bus
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           sel_q, sel_d;
  logic           id_q, id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-2:0]   res_q, res_d;
  logic [W-1:0]   y_q, y_d;
  logic           y_id_q, y_id_d;
  logic           y_vld_q, y_vld_d;
  logic           gnt0_q, gnt0_d;
  logic           gnt1_q, gnt1_d;
  logic           busy_q, busy_d;
  logic           win1;
  logic           res_bit;
  logic [W-1:0]   word;

`ifdef FN_SW_SCHED_RR_EN
  logic           last_id_q, last_id_d;

  assign win1 = bus.req1 & (~bus.req0 | ~last_id_q);
`else
  assign win1 = bus.req1 & ~bus.req0;
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sel_d     = sel_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    y_d       = y_q;
    y_id_d    = y_id_q;
    y_vld_d   = 1'b0;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
`ifdef FN_SW_SCHED_RR_EN
    last_id_d = last_id_q;
`endif
    res_bit   = sel_q ? (a_q[cnt_q] ^ b_q[cnt_q]) : (a_q[cnt_q] & b_q[cnt_q]);
    word      = {res_bit, res_q};

    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          a_d     = win1 ? bus.a1 : bus.a0;
          b_d     = win1 ? bus.b1 : bus.b0;
          sel_d   = win1 ? bus.sel1 : bus.sel0;
          id_d    = win1;
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Result bits enter at the MSB so bit 0 lands at the LSB after W shifts.
        res_d = word[W-1:1];
        if (cnt_q == CNT_LAST) begin
          y_d     = word;
          y_id_d  = id_q;
          y_vld_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
`ifdef FN_SW_SCHED_RR_EN
        last_id_d = y_id_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= 1'b0;
      id_q      <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
      y_q       <= '0;
      y_id_q    <= 1'b0;
      y_vld_q   <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FN_SW_SCHED_RR_EN
      last_id_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      y_q       <= y_d;
      y_id_q    <= y_id_d;
      y_vld_q   <= y_vld_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      busy_q    <= busy_d;
`ifdef FN_SW_SCHED_RR_EN
      last_id_q <= last_id_d;
`endif
    end
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.y     = y_q;
  assign bus.y_vld = y_vld_q;
  assign bus.y_id  = y_id_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_fn_sw_sched.sv
// Directed self-checking bench for fn_sw_sched; expected values are hand-computed.
module tb_fn_sw_sched;
  localparam int W = 8;
`ifdef FN_SW_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   cycle = 0;
  int   vld_cnt = 0;
  int   gnt0_cnt = 0;
  int   n;
  int   snap;
  int   prev_cyc;
  logic exp_id;

  always #5 clk = ~clk;

  fn_sw_sched_if #(.W(W)) bus ();

  fn_sw_sched #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.y_vld) vld_cnt++;
    if (bus.gnt0) gnt0_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic applyStimulus(input logic r0, input logic [W-1:0] x0, input logic [W-1:0] z0,
                               input logic s0, input logic r1, input logic [W-1:0] x1,
                               input logic [W-1:0] z1, input logic s1);
    bus.req0 = r0; bus.a0 = x0; bus.b0 = z0; bus.sel0 = s0;
    bus.req1 = r1; bus.a1 = x1; bus.b1 = z1; bus.sel1 = s1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Ticks until the chosen output (0=gnt0, 1=gnt1, 2=y_vld) is high; n = ticks taken, -1 on timeout.
  task automatic tickUntil(input int which, input int limit, output int cnt);
    logic hit;
    cnt = -1;
    hit = 1'b0;
    for (int i = 1; i <= limit && !hit; i++) begin
      tick();
      case (which)
        0:       hit = bus.gnt0;
        1:       hit = bus.gnt1;
        default: hit = bus.y_vld;
      endcase
      if (hit) cnt = i;
    end
  endtask

  initial begin
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    tick();
    tick();
    checkOutput("rst_gnt0", bus.gnt0, 0);
    checkOutput("rst_gnt1", bus.gnt1, 0);
    checkOutput("rst_y", bus.y, 0);
    checkOutput("rst_y_vld", bus.y_vld, 0);
    checkOutput("rst_y_id", bus.y_id, 0);
    checkOutput("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();

    // Requester 0 XOR: A5 ^ 0F = AA
    applyStimulus(1, 8'hA5, 8'h0F, 1, 0, 8'h00, 8'h00, 0);
    tick();
    checkOutput("t1_gnt0", bus.gnt0, 1);
    checkOutput("t1_gnt1", bus.gnt1, 0);
    checkOutput("t1_busy", bus.busy, 1);
    applyStimulus(0, 8'hA5, 8'h0F, 1, 0, 8'h00, 8'h00, 0);
    tickUntil(2, 12, n);
    checkOutput("t1_latency", n, W);
    checkOutput("t1_y", bus.y, 8'hAA);
    checkOutput("t1_y_id", bus.y_id, 0);
    checkOutput("t1_busy_done", bus.busy, 1);
    tick();
    checkOutput("t1_vld_drop", bus.y_vld, 0);
    checkOutput("t1_busy_drop", bus.busy, 0);
    checkOutput("t1_y_hold", bus.y, 8'hAA);

    // Requester 1 AND: F0 & 3C = 30, no gnt0
    snap = gnt0_cnt;
    applyStimulus(0, 8'h00, 8'h00, 0, 1, 8'hF0, 8'h3C, 0);
    tickUntil(1, 3, n);
    checkOutput("t2_gnt1", n, 1);
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'hF0, 8'h3C, 0);
    tickUntil(2, 12, n);
    checkOutput("t2_latency", n, W);
    checkOutput("t2_y", bus.y, 8'h30);
    checkOutput("t2_y_id", bus.y_id, 1);
    tick();
    checkOutput("t2_no_gnt0", gnt0_cnt - snap, 0);

    // Operands change right after capture: FF ^ 81 = 7E
    applyStimulus(1, 8'hFF, 8'h81, 1, 0, 8'h00, 8'h00, 0);
    tickUntil(0, 3, n);
    checkOutput("t3_gnt0", n, 1);
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    tickUntil(2, 12, n);
    checkOutput("t3_y", bus.y, 8'h7E);
    tick();

    // req1 arrives during req0's RUN: gnt1 at E10, result after E18 (3C ^ 0F = 33)
    applyStimulus(1, 8'h11, 8'h22, 1, 0, 8'h00, 8'h00, 0);
    tickUntil(0, 3, n);
    checkOutput("t4_gnt0", n, 1);
    applyStimulus(0, 8'h11, 8'h22, 1, 0, 8'h00, 8'h00, 0);
    tick();
    tick();
    applyStimulus(0, 8'h11, 8'h22, 1, 1, 8'h3C, 8'h0F, 1);
    tickUntil(1, 15, n);
    checkOutput("t4_gnt1_edge", n, 8);
    applyStimulus(0, 8'h11, 8'h22, 1, 0, 8'h3C, 8'h0F, 1);
    tickUntil(2, 12, n);
    checkOutput("t4_latency", n, W);
    checkOutput("t4_y", bus.y, 8'h33);
    checkOutput("t4_y_id", bus.y_id, 1);
    tick();

    // Reset in the 4th RUN cycle discards the operation
    applyStimulus(1, 8'h5A, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
    tickUntil(0, 3, n);
    checkOutput("t5_gnt0", n, 1);
    applyStimulus(0, 8'h5A, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
    tick();
    tick();
    tick();
    snap = vld_cnt;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_y", bus.y, 0);
    checkOutput("t5_y_id", bus.y_id, 0);
    checkOutput("t5_busy", bus.busy, 0);
    checkOutput("t5_y_vld", bus.y_vld, 0);
    tick();
    tick();
    checkOutput("t5_no_vld", vld_cnt - snap, 0);

    // Release with a tie: gnt0 first, then steady-state arbitration (FF&0F=0F, FF&F0=F0)
    rst_n = 1'b1;
    applyStimulus(1, 8'hFF, 8'h0F, 0, 1, 8'hFF, 8'hF0, 0);
    tickUntil(0, 3, n);
    checkOutput("t6_gnt0_first", n, 1);
    checkOutput("t6_gnt1_quiet", bus.gnt1, 0);
    prev_cyc = cycle;
    for (int k = 0; k < 4; k++) begin
      tickUntil(2, 15, n);
      exp_id = RR ? k[0] : 1'b0;
      checkOutput($sformatf("t6_id%0d", k), bus.y_id, exp_id);
      checkOutput($sformatf("t6_y%0d", k), bus.y, exp_id ? 8'hF0 : 8'h0F);
      checkOutput($sformatf("t6_gap%0d", k), cycle - prev_cyc, (k == 0) ? W : W + 2);
      prev_cyc = cycle;
    end
    applyStimulus(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
